dmem_responder: RTL



---
 rtl/dmem_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with read-first registered word output,
// a small MMIO window (cycle counter, tohost/halt) and a post-reset clear sequencer.
module dmem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic [31:0] addrb,
  input  logic [3:0]  web,
  input  logic [31:0] dib,
  output logic [31:0] DMEM_word,
  output logic        busy,
  output logic        store_fault,
  output logic        load_fault,
  output logic        halt,
  output logic [31:0] tohost
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t         state;
  logic [AW-1:0]  ptr;
  logic [63:0]    cyc_cnt;
  logic [31:0]    mem [DEPTH];

  logic           acc, is_mmio, is_ram, is_oor, web_ok;
  logic [AW-1:0]  widx;
  logic [31:0]    mmio_rd;
  logic           ram_we, tohost_we, sf_nxt, lf_nxt;

  always_comb begin
    case (web)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: web_ok = 1'b1;
      default:                            web_ok = 1'b0;
    endcase
  end

  // MMIO decode wins over RAM so the window is reachable whatever DEPTH is
  assign acc       = (state == READY) && enb;
  assign is_mmio   = (addrb[31:4] == MMIO_BASE[31:4]);
  assign is_ram    = !is_mmio && (addrb < RAM_LIMIT);
  assign is_oor    = !is_mmio && !is_ram;
  assign widx      = addrb[AW+1:2];
  assign ram_we    = acc && is_ram && web_ok;
  assign tohost_we = acc && is_mmio && (addrb[3:2] == 2'd2) && web_ok && (web != 4'b0000);
  assign sf_nxt    = acc && (!web_ok || (is_oor && (web != 4'b0000)));
  assign lf_nxt    = acc && is_oor && (web == 4'b0000);

  always_comb begin
    case (addrb[3:2])
      2'd0:    mmio_rd = cyc_cnt[31:0];
      2'd1:    mmio_rd = cyc_cnt[63:32];
      2'd2:    mmio_rd = tohost;
      default: mmio_rd = 32'h0;
    endcase
  end

  // Single write port shared by the clear sequencer and lane stores
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr] <= 32'h0;
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (web[i]) mem[widx][8*i +: 8] <= dib[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      busy        <= 1'b1;
      ptr         <= '0;
      cyc_cnt     <= 64'h0;
      DMEM_word   <= 32'h0;
      store_fault <= 1'b0;
      load_fault  <= 1'b0;
      halt        <= 1'b0;
      tohost      <= 32'h0;
    end else begin
      store_fault <= sf_nxt;
      load_fault  <= lf_nxt;
      case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          cyc_cnt <= cyc_cnt + 64'd1;
          if (enb) begin
            if (is_mmio)     DMEM_word <= mmio_rd;
            else if (is_ram) DMEM_word <= mem[widx];
            else             DMEM_word <= 32'h0;
          end
          if (tohost_we) begin
            halt <= 1'b1;
            for (int i = 0; i < 4; i++)
              if (web[i]) tohost[8*i +: 8] <= dib[8*i +: 8];
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
